// File: rtl/hu_arb_pkg.sv
// Shared types and helpers for the hu_arb_mux arbitrating multiplexer.
// Holds the grant FSM state encoding and the channel-index width function.
package hu_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  function automatic int hu_idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hu_rr_pick.sv
// Combinational rotating picker: first requester at or after ptr, wrapping.
// A fixed-priority picker is the same block with ptr tied to zero.
module hu_rr_pick #(
  parameter int n  = 4,
  parameter int iw = 2
) (
  input  logic [n-1:0]  req,
  input  logic [iw-1:0] ptr,
  output logic [n-1:0]  gnt,
  output logic [iw-1:0] idx,
  output logic          any
);

  int j;

  // Scan from the farthest position back towards ptr so the nearest requester wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = |req;
    j   = 0;
    for (int k = n - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if (req[j[iw-1:0]]) begin
        gnt = '0;
        gnt[j[iw-1:0]] = 1'b1;
        idx = j[iw-1:0];
      end
    end
  end

endmodule

// File: rtl/hu_arb_mux.sv
// Registered N-channel arbitrating mux with optional packet lock.
// One beat per cycle moves from the granted input into a single output register.
module hu_arb_mux
  import hu_arb_pkg::*;
#(
  parameter int  channels = 4,
  parameter type seltype  = logic [7:0],
  parameter bit  rr_mode  = 1'b1,
  parameter bit  pkt_lock = 1'b1,
  localparam int idx_w    = hu_idx_width(channels)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [channels-1:0] in_valid,
  output logic [channels-1:0] in_ready,
  input  seltype              in_data [channels],
  input  logic [channels-1:0] in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output seltype              out_data,
  output logic                out_last,
  output logic [idx_w-1:0]    out_chan,
  output arb_state_t          dbg_state
);

  // Handshake: a beat moves on any port in a cycle where its valid and ready
  // are both high at the rising edge; valid never waits on ready, while
  // in_ready is allowed to follow out_ready combinationally.

  localparam int dw = $bits(seltype);

  arb_state_t           state_q, state_d;
  logic [idx_w-1:0]     lock_q, lock_d;
  logic [idx_w-1:0]     ptr_q, ptr_d;
  logic [idx_w-1:0]     pick_ptr;
  logic [channels-1:0]  pick_gnt;
  logic [idx_w-1:0]     pick_idx;
  logic                 pick_any;
  logic [channels-1:0]  lock_gnt;
  logic [channels-1:0]  gnt_vec;
  logic [idx_w-1:0]     g;
  logic                 load_ok;
  logic                 accept;
  logic                 sel_last;
  logic [dw-1:0]        sel_bits;

  assign pick_ptr = rr_mode ? ptr_q : '0;

  hu_rr_pick #(
    .n  (channels),
    .iw (idx_w)
  ) u_pick (
    .req (in_valid),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    lock_gnt = '0;
    lock_gnt[lock_q] = 1'b1;
  end

  // Grant, handshake and one-hot AND-OR payload selection.
  always_comb begin
    load_ok  = !out_valid || out_ready;
    g        = (state_q == ARB_LOCK) ? lock_q   : pick_idx;
    gnt_vec  = (state_q == ARB_LOCK) ? lock_gnt : pick_gnt;
    in_ready = (rst_n && load_ok && pick_any) ? gnt_vec : '0;
    accept   = |(in_valid & in_ready);
    sel_last = |(in_last & gnt_vec);
    sel_bits = '0;
    for (int i = 0; i < channels; i++) begin
      sel_bits = sel_bits | (in_data[i] & {dw{gnt_vec[i]}});
    end
  end

  // Lock tracking and round-robin pointer advance.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (accept && pkt_lock && !sel_last) begin
          state_d = ARB_LOCK;
          lock_d  = g;
        end
      end
      ARB_LOCK: begin
        if (accept && sel_last) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (rr_mode && accept && (sel_last || !pkt_lock)) begin
      if (int'(g) == channels - 1) ptr_d = '0;
      else                          ptr_d = g + idx_w'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      lock_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= seltype'(sel_bits);
      out_last  <= sel_last;
      out_chan  <= g;
    end else if (load_ok) begin
      out_valid <= 1'b0;
    end
  end

  assign dbg_state = state_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready));

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)
                                   && $stable(out_chan)));

  a_stall_no_ready: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |-> (in_ready == '0));

endmodule
